core_riscv_mc: RTL and testbench
================================

Name: core_riscv_mc

Overview:
Multi-cycle RV32I core and parametrised successor to the single-cycle core. It reuses the existing Decoder, ALU_RiscV and RegFile.
Instruction fetch and data access share one external memory port with a req/ready handshake, so variable-latency memory is supported.
Adds a configurable reset vector, a retired-instruction counter, a bus timeout, and a trap/halt state with cause reporting.

Parameters:
RESET_PC, 32'h0000_0000, pc value loaded on reset.
CNT_W, 32, width of instret counter.
TIMEOUT, 0, max cycles mem_req may wait for mem_ready; 0 disables the timeout.
TO_W, 8, width of timeout counter; TIMEOUT must be < 2^TO_W.

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  synchronous, active-high reset
mem_req  out  1  memory access request
mem_we  out  1  write enable, valid with mem_req
mem_size  out  3  access size, decoder memory_size encoding; word for fetch
mem_addr  out  32  byte address
mem_wdata  out  32  store data (rs2 value)
mem_rdata  in  32  read data, size-extended by memory, sampled when mem_ready=1
mem_ready  in  1  access complete; may be high in the same cycle as mem_req
pc  out  32  current program counter
halted  out  1  core is in TRAP
trap_cause  out  2  0 system stop, 1 illegal instr, 2 misaligned target, 3 bus timeout
instret  out  CNT_W  retired instruction count, wraps at 2^CNT_W

Behaviour:
- Reset (reset=1 at posedge): state=FETCH, pc=RESET_PC, instr reg=0, instret=0, halted=0, trap_cause=0, timeout counter=0.
- Reset affects outputs from the next cycle: mem_req drops mid-access and any pending access is abandoned. The memory side must tolerate the dropped request.
- FETCH state:
  - mem_req=1, mem_we=0, mem_size=word, mem_addr=pc.
  - Held stable until mem_ready.
  - On mem_ready: instr reg<=mem_rdata, go to EXEC.
- EXEC state (1 cycle): decode instr reg; immediates and operand muxes as in the single-cycle datapath. Priority order:
  - illegal_flag -> TRAP, cause 1.
  - stop_signal -> TRAP, cause 0.
  - Next-pc target has bit1 set -> TRAP, cause 2. Next-pc is pc+4, pc+imm_B (taken), pc+imm_J, or (rs1+imm_I)&~1 for jalr; the jalr LSB is cleared.
  - memory_require -> MEM.
  - Otherwise: retire.
- MEM state:
  - mem_req=1, mem_addr=alu_result, mem_we=memory_write_enable, mem_size=memory_size, mem_wdata=rd2. All held stable until mem_ready.
  - On mem_ready: retire. Loads write mem_rdata to rd.
- Retire (single cycle, last cycle of EXEC or MEM):
  - RF write enable = decoder reg_file_write_enable, gated to this cycle only.
  - pc<=next-pc, instret<=instret+1, state<=FETCH.
  - x0 stays zero.
- TRAP state:
  - halted=1, mem_req=0, pc frozen at the trapping instruction, no RF writes, instret unchanged.
  - Exit only by reset.
- Timeout:
  - Counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 && mem_ready=0.
  - When the count reaches TIMEOUT (TIMEOUT≠0): TRAP, cause 3; mem_req=0 from the next cycle.
  - mem_ready arriving in the same cycle as the limit wins: access completes, no trap.
- Latency with zero-wait memory: ALU/branch/jump 2 cycles, load/store 3 cycles. Each wait cycle adds one.
- Outputs are registered state or combinational from registered state only. No combinational path from mem_ready to mem_req/mem_addr.

Test Plan:
1. RESET_PC=32'h100, zero-wait, instr 0x00500093 (addi x1,x0,5) -> first mem_addr=0x100. After 2 cycles pc=0x104, instret=1, x1=5.
2. Fetch with mem_ready delayed 3 cycles -> mem_req/mem_addr/mem_size stable for 4 cycles; retire occurs exactly once, instret=1.
3. sw x1,8(x0) then lw x2,8(x0), x1=5 ->
   - Store MEM cycle: mem_we=1, addr=8, wdata=5, size=word.
   - Load: x2=5.
   - instret=2 after 6 cycles (zero-wait).
4. beq x0,x0,-8 at pc=0x110 -> pc=0x108. jalr x0,1(x1) with x1=5 -> target 6 -> halted=1, cause 2, pc unchanged.
5. Fetch returns 0x00000000 -> halted=1, cause 1, mem_req=0 for 10 following cycles, instret unchanged.
6. TIMEOUT=4, mem_ready held 0 -> after 4 waiting cycles halted=1, cause 3. Assert reset for 1 cycle -> halted=0, pc=RESET_PC, mem_req=1 the following cycle.

Source files
------------

// File: rtl/core_riscv_mc.sv
// Multi-cycle RV32I core: FETCH/EXEC/MEM/TRAP sequencer around an inline decoder,
// ALU and register file, sharing one req/ready memory port for fetch and data.
module core_riscv_mc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32,
  parameter int          TIMEOUT  = 0,
  parameter int          TO_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [2:0]       mem_size,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic [31:0]      pc,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_TRAP  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    WB_ALU, WB_IMM, WB_AUIPC, WB_PC4, WB_MEM
  } wb_sel_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [1:0]       cause_q, cause_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [31:0]      rf_q [32];

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rd1, rd2;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign funct3 = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign funct7 = instr_q[31:25];

  assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u = {instr_q[31:12], 12'b0};
  assign imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

  assign rd1 = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rd2 = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

  logic        illegal_flag, stop_signal, memory_require, memory_write_enable;
  logic        reg_file_write_enable, use_imm, alu_sub;
  logic        is_branch, is_jal, is_jalr;
  logic [2:0]  alu_f3;
  logic [31:0] alu_imm;
  wb_sel_t     wb_sel;

  always_comb begin
    illegal_flag          = 1'b0;
    stop_signal           = 1'b0;
    memory_require        = 1'b0;
    memory_write_enable   = 1'b0;
    reg_file_write_enable = 1'b0;
    use_imm               = 1'b0;
    alu_sub               = 1'b0;
    alu_f3                = funct3;
    alu_imm               = imm_i;
    wb_sel                = WB_ALU;
    is_branch             = 1'b0;
    is_jal                = 1'b0;
    is_jalr               = 1'b0;
    case (opcode)
      7'b0110111: begin reg_file_write_enable = 1'b1; wb_sel = WB_IMM;   end
      7'b0010111: begin reg_file_write_enable = 1'b1; wb_sel = WB_AUIPC; end
      7'b1101111: begin reg_file_write_enable = 1'b1; wb_sel = WB_PC4; is_jal = 1'b1; end
      7'b1100111: begin
        illegal_flag          = (funct3 != 3'd0);
        reg_file_write_enable = 1'b1;
        wb_sel                = WB_PC4;
        is_jalr               = 1'b1;
      end
      7'b1100011: begin
        illegal_flag = (funct3[2:1] == 2'b01);
        is_branch    = 1'b1;
      end
      7'b0000011: begin
        illegal_flag          = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        memory_require        = 1'b1;
        reg_file_write_enable = 1'b1;
        wb_sel                = WB_MEM;
        use_imm               = 1'b1;
        alu_f3                = 3'd0;
      end
      7'b0100011: begin
        illegal_flag        = (funct3 > 3'd2);
        memory_require      = 1'b1;
        memory_write_enable = 1'b1;
        use_imm             = 1'b1;
        alu_imm             = imm_s;
        alu_f3              = 3'd0;
      end
      7'b0010011: begin
        illegal_flag = ((funct3 == 3'd1) && (funct7 != 7'h00)) ||
                       ((funct3 == 3'd5) && (funct7 != 7'h00) && (funct7 != 7'h20));
        reg_file_write_enable = 1'b1;
        use_imm               = 1'b1;
        alu_sub               = (funct3 == 3'd5) && instr_q[30];
      end
      7'b0110011: begin
        illegal_flag = !((funct7 == 7'h00) ||
                         ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
        reg_file_write_enable = 1'b1;
        alu_sub               = instr_q[30];
      end
      7'b0001111: ;  // fence: no ordering to enforce on a single in-order port
      7'b1110011: stop_signal = 1'b1;
      default:    illegal_flag = 1'b1;
    endcase
  end

  logic [31:0] alu_b, alu_result;

  assign alu_b = use_imm ? alu_imm : rd2;

  always_comb begin
    alu_result = 32'd0;
    case (alu_f3)
      3'd0: alu_result = alu_sub ? (rd1 - alu_b) : (rd1 + alu_b);
      3'd1: alu_result = rd1 << alu_b[4:0];
      3'd2: alu_result = {31'd0, $signed(rd1) < $signed(alu_b)};
      3'd3: alu_result = {31'd0, rd1 < alu_b};
      3'd4: alu_result = rd1 ^ alu_b;
      3'd5: alu_result = alu_sub ? 32'($signed(rd1) >>> alu_b[4:0]) : (rd1 >> alu_b[4:0]);
      3'd6: alu_result = rd1 | alu_b;
      3'd7: alu_result = rd1 & alu_b;
      default: alu_result = 32'd0;
    endcase
  end

  logic        taken;
  logic [31:0] pc_plus4, next_pc, wb_data;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'd0: taken = (rd1 == rd2);
      3'd1: taken = (rd1 != rd2);
      3'd4: taken = ($signed(rd1) < $signed(rd2));
      3'd5: taken = ($signed(rd1) >= $signed(rd2));
      3'd6: taken = (rd1 < rd2);
      3'd7: taken = (rd1 >= rd2);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = pc_plus4;
    if (is_jal)                 next_pc = pc_q + imm_j;
    else if (is_jalr)           next_pc = (rd1 + imm_i) & ~32'd1;
    else if (is_branch && taken) next_pc = pc_q + imm_b;
  end

  always_comb begin
    wb_data = alu_result;
    case (wb_sel)
      WB_IMM:   wb_data = imm_u;
      WB_AUIPC: wb_data = pc_q + imm_u;
      WB_PC4:   wb_data = pc_plus4;
      WB_MEM:   wb_data = mem_rdata;
      default:  wb_data = alu_result;
    endcase
  end

  // The limit is hit when this waiting cycle would bring the count up to TIMEOUT;
  // mem_ready in that same cycle is checked first and wins.
  logic timeout_hit, retire, rf_wr;

  assign timeout_hit = (TIMEOUT != 0) && ((to_cnt_q + TO_W'(1)) == TO_W'(TIMEOUT));

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    cause_d   = cause_q;
    to_cnt_d  = to_cnt_q;
    retire    = 1'b0;
    rf_wr     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_size  = 3'b010;
    mem_addr  = pc_q;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          instr_d  = mem_rdata;
          to_cnt_d = '0;
          state_d  = S_EXEC;
        end else if (timeout_hit) begin
          cause_d = 2'd3;
          state_d = S_TRAP;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_EXEC: begin
        to_cnt_d = '0;
        if (illegal_flag) begin
          cause_d = 2'd1;
          state_d = S_TRAP;
        end else if (stop_signal) begin
          cause_d = 2'd0;
          state_d = S_TRAP;
        end else if (next_pc[1]) begin
          cause_d = 2'd2;
          state_d = S_TRAP;
        end else if (memory_require) begin
          state_d = S_MEM;
        end else begin
          retire = 1'b1;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = memory_write_enable;
        mem_size = funct3;
        mem_addr = alu_result;
        if (mem_ready) begin
          retire = 1'b1;
        end else if (timeout_hit) begin
          cause_d = 2'd3;
          state_d = S_TRAP;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: ;
    endcase
    if (retire) begin
      rf_wr     = reg_file_write_enable;
      pc_d      = next_pc;
      instret_d = instret_q + CNT_W'(1);
      to_cnt_d  = '0;
      state_d   = S_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      instret_q <= '0;
      cause_q   <= 2'd0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      cause_q   <= cause_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && rf_wr && (rd != 5'd0)) rf_q[rd] <= wb_data;
  end

  assign mem_wdata  = rd2;
  assign pc         = pc_q;
  assign halted     = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign instret    = instret_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_core_riscv_mc.sv
// Bench for core_riscv_mc: table of small programs run to a trap, plus
// hand-written cycle-exact sequences for latency, wait states, traps and timeout.
module tb_core_riscv_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we;
  logic [2:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, pc;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;
  logic        halted;
  logic [1:0]  trap_cause, dbg_state;
  logic [31:0] instret;

  always #5 clk = ~clk;

  core_riscv_mc #(.RESET_PC(32'h100), .CNT_W(32), .TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .halted(halted), .trap_cause(trap_cause), .instret(instret), .dbg_state(dbg_state)
  );

  // Memory model: 128 words, wait_cfg wait cycles per access, block holds ready low.
  logic [31:0] mem [128];
  int          wait_cfg = 0;
  int          wcnt = 0;
  logic        block = 1'b0;
  int          st_count = 0;
  logic [31:0] st_addr = 32'd0;
  logic [31:0] st_data = 32'd0;

  always @(negedge clk) begin
    if (reset) begin
      mem_ready = 1'b0;
      wcnt = 0;
    end else if (mem_req && !block && (wcnt >= wait_cfg)) begin
      mem_ready = 1'b1;
      mem_rdata = mem[mem_addr[8:2]];
      if (mem_we) begin
        mem[mem_addr[8:2]] = mem_wdata;
        st_count++;
        st_addr = mem_addr;
        st_data = mem_wdata;
      end
      wcnt = 0;
    end else begin
      mem_ready = 1'b0;
      if (mem_req) wcnt++;
      else wcnt = 0;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    st_count = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic load_prog(input logic [31:0] p [6]);
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    for (int i = 0; i < 6; i++) mem[64 + i] = p[i];
  endtask

  typedef struct {
    logic [31:0] prog [6];
    logic [31:0] exp_pc;
    logic [31:0] exp_instret;
    logic [1:0]  exp_cause;
    int          exp_stores;
    logic [31:0] exp_st_addr;
    logic [31:0] exp_st_data;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] p0, p1, p2, p3, p4, p5,
                              input logic [31:0] epc, eir, input logic [1:0] ec,
                              input int ns, input logic [31:0] ea, ed);
    vec_t v;
    v.prog[0] = p0; v.prog[1] = p1; v.prog[2] = p2;
    v.prog[3] = p3; v.prog[4] = p4; v.prog[5] = p5;
    v.exp_pc = epc; v.exp_instret = eir; v.exp_cause = ec;
    v.exp_stores = ns; v.exp_st_addr = ea; v.exp_st_data = ed;
    return v;
  endfunction

  localparam logic [31:0] ADDI_X1_5   = 32'h0050_0093;
  localparam logic [31:0] SW_X1_8     = 32'h0010_2423;
  localparam logic [31:0] LW_X2_8     = 32'h0080_2103;
  localparam logic [31:0] SW_X2_12    = 32'h0020_2623;
  localparam logic [31:0] SW_X3_16    = 32'h0030_2823;
  localparam logic [31:0] ECALL       = 32'h0000_0073;

  vec_t vecs [10];
  logic [31:0] prog [6];

  initial begin
    vecs[0] = mk(ADDI_X1_5, SW_X1_8, 0, 0, 0, 0, 32'h108, 2, 2'd1, 1, 32'd8, 32'd5);
    vecs[1] = mk(ADDI_X1_5, SW_X1_8, LW_X2_8, SW_X2_12, 0, 0, 32'h110, 4, 2'd1, 2, 32'd12, 32'd5);
    vecs[2] = mk(32'hFFD0_0093, 32'h0010_81B3, SW_X3_16, 0, 0, 0, 32'h10C, 3, 2'd1, 1, 32'd16, 32'hFFFF_FFFA);
    vecs[3] = mk(32'hFF00_0093, 32'h4020_D193, SW_X3_16, 0, 0, 0, 32'h10C, 3, 2'd1, 1, 32'd16, 32'hFFFF_FFFC);
    vecs[4] = mk(32'h1234_51B7, SW_X3_16, 0, 0, 0, 0, 32'h108, 2, 2'd1, 1, 32'd16, 32'h1234_5000);
    vecs[5] = mk(32'h0080_01EF, 0, SW_X3_16, 0, 0, 0, 32'h10C, 2, 2'd1, 1, 32'd16, 32'h104);
    vecs[6] = mk(ECALL, 0, 0, 0, 0, 0, 32'h100, 0, 2'd0, 0, 32'd0, 32'd0);
    vecs[7] = mk(ADDI_X1_5, 32'h0010_8067, 0, 0, 0, 0, 32'h104, 1, 2'd2, 0, 32'd0, 32'd0);
    vecs[8] = mk(32'h0100_006F, 0, ECALL, 0, 32'hFE00_0CE3, 0, 32'h108, 2, 2'd0, 0, 32'd0, 32'd0);
    vecs[9] = mk(32'h0000_1463, ADDI_X1_5, SW_X1_8, 0, 0, 0, 32'h10C, 3, 2'd1, 1, 32'd8, 32'd5);

    // Table: each program runs until it traps, then the final state is compared.
    for (int i = 0; i < 10; i++) begin
      wait_cfg = 0;
      load_prog(vecs[i].prog);
      do_reset();
      cycles(60);
      check($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("v%0d_instret", i), instret, vecs[i].exp_instret);
      check($sformatf("v%0d_halted", i), {31'd0, halted}, 32'd1);
      check($sformatf("v%0d_cause", i), {30'd0, trap_cause}, {30'd0, vecs[i].exp_cause});
      check($sformatf("v%0d_req_off", i), {31'd0, mem_req}, 32'd0);
      check($sformatf("v%0d_stores", i), st_count, vecs[i].exp_stores);
      if (vecs[i].exp_stores > 0) begin
        check($sformatf("v%0d_st_addr", i), st_addr, vecs[i].exp_st_addr);
        check($sformatf("v%0d_st_data", i), st_data, vecs[i].exp_st_data);
      end
    end

    // Zero-wait ALU instruction: two cycles from reset to retire.
    prog = '{ADDI_X1_5, 0, 0, 0, 0, 0};
    load_prog(prog);
    wait_cfg = 0;
    do_reset();
    check("reset_pc", pc, 32'h100);
    check("reset_instret", instret, 32'd0);
    check("reset_halted", {31'd0, halted}, 32'd0);
    check("reset_cause", {30'd0, trap_cause}, 32'd0);
    check("first_req", {31'd0, mem_req}, 32'd1);
    check("first_addr", mem_addr, 32'h100);
    cycles(1);
    check("exec_no_req", {31'd0, mem_req}, 32'd0);
    cycles(1);
    check("alu_pc", pc, 32'h104);
    check("alu_instret", instret, 32'd1);

    // Fetch with three wait cycles: request held stable, one retire.
    wait_cfg = 3;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      check($sformatf("wait_req_c%0d", c), {31'd0, mem_req}, 32'd1);
      check($sformatf("wait_addr_c%0d", c), mem_addr, 32'h100);
      check($sformatf("wait_size_c%0d", c), {29'd0, mem_size}, 32'd2);
      check($sformatf("wait_ir_c%0d", c), instret, 32'd0);
      cycles(1);
    end
    cycles(1);
    check("wait_pc", pc, 32'h104);
    check("wait_instret", instret, 32'd1);
    cycles(3);
    check("wait_instret_hold", instret, 32'd1);

    // Store then load, cycle by cycle with zero-wait memory.
    prog = '{ADDI_X1_5, SW_X1_8, LW_X2_8, SW_X2_12, 0, 0};
    load_prog(prog);
    wait_cfg = 0;
    do_reset();
    cycles(4);
    check("sw_req", {31'd0, mem_req}, 32'd1);
    check("sw_we", {31'd0, mem_we}, 32'd1);
    check("sw_addr", mem_addr, 32'd8);
    check("sw_wdata", mem_wdata, 32'd5);
    check("sw_size", {29'd0, mem_size}, 32'd2);
    cycles(1);
    check("sw_pc", pc, 32'h108);
    check("sw_instret", instret, 32'd2);
    cycles(2);
    check("lw_req", {31'd0, mem_req}, 32'd1);
    check("lw_we", {31'd0, mem_we}, 32'd0);
    check("lw_addr", mem_addr, 32'd8);
    cycles(1);
    check("lw_pc", pc, 32'h10C);
    check("lw_instret", instret, 32'd3);
    cycles(3);
    check("lw_result", st_data, 32'd5);
    check("lw_result_addr", st_addr, 32'd12);

    // Illegal all-zero instruction: trap and stay quiet.
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    do_reset();
    cycles(2);
    check("ill_halted", {31'd0, halted}, 32'd1);
    check("ill_cause", {30'd0, trap_cause}, 32'd1);
    check("ill_pc", pc, 32'h100);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("ill_req_c%0d", c), {31'd0, mem_req}, 32'd0);
      cycles(1);
    end
    check("ill_instret", instret, 32'd0);

    // Bus timeout with ready held low, then recovery through reset.
    block = 1'b1;
    do_reset();
    cycles(3);
    check("to_not_yet", {31'd0, halted}, 32'd0);
    check("to_req_wait", {31'd0, mem_req}, 32'd1);
    cycles(1);
    check("to_halted", {31'd0, halted}, 32'd1);
    check("to_cause", {30'd0, trap_cause}, 32'd3);
    check("to_req_off", {31'd0, mem_req}, 32'd0);
    block = 1'b0;
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    check("rec_halted", {31'd0, halted}, 32'd0);
    check("rec_pc", pc, 32'h100);
    check("rec_req", {31'd0, mem_req}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
